dtbdm_window_gen: RTL and testbench
===================================

# dtbdm_window_gen

Raster-to-window stage of the DTBDM de-noiser, directly upstream of the isolation stage. Accepts one 8-bit grey pixel per valid cycle in raster order and buffers two image lines. For every pixel that completes a full 3x3 neighbourhood, emits the nine window pixels (a,b,c / d,fij,e / f,g,h) with a one-cycle valid strobe, ready for the isolation stage's iDataValid and pixel inputs.

## Interface
Parameters:
- IMG_WIDTH, 320, pixels per line (>= 3)
- IMG_HEIGHT, 240, lines per frame (>= 3)

Ports:
- iClk  in  1  clock; all logic on rising edge
- iRst  in  1  reset; synchronous, active-high
- iDataValid  in  1  input pixel qualifier
- iSof  in  1  start of frame; meaningful only with iDataValid; marks pixel (0,0)
- iv8Pixel  in  8  input pixel
- ov8Pixel_a, _b, _c  out  8 each  top row, columns c-2, c-1, c
- ov8Pixel_d, _fij, _e  out  8 each  middle row, columns c-2, c-1, c
- ov8Pixel_f, _g, _h  out  8 each  bottom row, columns c-2, c-1, c
- oDataValid  out  1  window valid, one cycle per window
- oFrameDone  out  1  one-cycle pulse coincident with the frame's last window

## Operation
- Counters: col in 0..IMG_WIDTH-1, row in 0..IMG_HEIGHT-1; advance only on accepted pixels; col wraps to 0 and row increments at IMG_WIDTH-1.
- Two line buffers of IMG_WIDTH x 8. Line buffer 1 holds row r-1 and line buffer 2 holds row r-2. On each accepted pixel, read both at address col (combinational), write line buffer 2 with line buffer 1's old data and line buffer 1 with iv8Pixel.
- A 3x3 register window shifts left by one column per accepted pixel. New column = {lb2 read, lb1 read, iv8Pixel}.
- Window emitted when the accepted pixel has row >= 2 and col >= 2. Centre is (row-1, col-1). Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Border pixels produce no window.
- FSM:
  - IDLE: wait for iDataValid&iSof. That pixel is accepted as (0,0); go to FILL.
  - FILL: rows 0-1; no output. Go to STREAM when row 2 begins.
  - STREAM: emit windows as above. After pixel (IMG_HEIGHT-1, IMG_WIDTH-1), go to DONE.
  - DONE: ignore pixels without iSof. iDataValid&iSof accepts that pixel as (0,0) and goes to FILL.
- iSof in FILL or STREAM: abandon the current frame; that pixel becomes (0,0) and the FSM goes to FILL. Stale line-buffer data is never emitted, because rows 0-1 emit nothing.
- iDataValid low: full stall; no counter, buffer or window change.

## Timing
- Latency: outputs are registered and appear on the cycle after the edge on which the completing pixel is accepted.
- oDataValid and oFrameDone are high for exactly one cycle per event and are 0 whenever no window is emitted.
- Window pixel outputs hold their last value while oDataValid is low.
- Back-to-back valid input gives back-to-back windows within a row. There are 2-cycle gaps at each line start (col 0,1).
- Reset values: all outputs 0, counters 0, FSM IDLE, window registers 0. Line-buffer contents are don't-care.
- iRst asserted mid-frame: takes effect at the next edge; the next frame needs iSof.

## Configuration
- DTBDM_WIN_CNT_EN:
  - Defined: adds output ov17WinCount (17 bits). It clears on accepted iSof and increments per emitted window. It saturates at 2^17-1, holds after oFrameDone, and resets to 0.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- dtbdm_pkg: FSM state encoding (IDLE, FILL, STREAM, DONE), window index constants (A=0, B=1, C=2, D=3, FIJ=4, E=5, F=6, G=7, H=8) shared with the isolation stage, and the pixel width (8).
- One sub-module: dtbdm_line_buffer (parameter DEPTH; write enable, address, write data, combinational read data), instantiated twice.

## Test plan
- IMG_WIDTH=5, IMG_HEIGHT=4; pixel = 10*row+col, continuous valid, iSof on the first pixel -> first window a..h = 0,1,2,10,11,12,20,21,22. Exactly 6 oDataValid pulses.
- Same frame -> last window = 12,13,14,22,23,24,32,33,34 with oFrameDone=1 on that cycle only.
- Same frame with iDataValid toggling 1,0,1,0 -> identical window sequence; no valid during stalls.
- iSof reasserted at pixel (2,3), then a fresh full frame -> no window from the aborted frame after the restart; 6 correct windows from the new frame.
- Extra pixels in DONE without iSof -> no output. Next iSof frame -> normal output.
- iRst asserted mid-STREAM -> all outputs 0 next cycle; with DTBDM_WIN_CNT_EN, ov17WinCount=0 after reset and equals 6 after a full frame.

Source files
------------

// File: rtl/dtbdm_pkg.sv
// dtbdm_pkg: shared FSM encoding, window index map and pixel width for the DTBDM de-noiser
package dtbdm_pkg;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
  localparam int WIN_A   = 0;
  localparam int WIN_B   = 1;
  localparam int WIN_C   = 2;
  localparam int WIN_D   = 3;
  localparam int WIN_FIJ = 4;
  localparam int WIN_E   = 5;
  localparam int WIN_F   = 6;
  localparam int WIN_G   = 7;
  localparam int WIN_H   = 8;
endpackage

// File: rtl/dtbdm_line_buffer.sv
// dtbdm_line_buffer: one image line of pixels, synchronous write, combinational read
module dtbdm_line_buffer
  import dtbdm_pkg::*;
#(
  parameter int DEPTH = 320
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [PIX_W-1:0]         i_wr_data,
  output logic [PIX_W-1:0]         o_rd_data
);
  logic [PIX_W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_addr] <= i_wr_data;
  assign o_rd_data = r_mem[i_addr];
endmodule

// File: rtl/dtbdm_window_gen.sv
// dtbdm_window_gen: raster pixels to 3x3 windows; define DTBDM_WIN_CNT_EN to add ov17WinCount
module dtbdm_window_gen
  import dtbdm_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iDataValid,
  input  logic             iSof,
  input  logic [PIX_W-1:0] iv8Pixel,
  output logic [PIX_W-1:0] ov8Pixel_a,
  output logic [PIX_W-1:0] ov8Pixel_b,
  output logic [PIX_W-1:0] ov8Pixel_c,
  output logic [PIX_W-1:0] ov8Pixel_d,
  output logic [PIX_W-1:0] ov8Pixel_fij,
  output logic [PIX_W-1:0] ov8Pixel_e,
  output logic [PIX_W-1:0] ov8Pixel_f,
  output logic [PIX_W-1:0] ov8Pixel_g,
  output logic [PIX_W-1:0] ov8Pixel_h,
`ifdef DTBDM_WIN_CNT_EN
  output logic [16:0]      ov17WinCount,
`endif
  output logic             oDataValid,
  output logic             oFrameDone
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  state_t r_state, w_next;
  logic [CW-1:0] r_col, w_addr;
  logic [RW-1:0] r_row;
  logic w_sof, w_accept, w_emit, w_done, w_col_last, w_row_last, r_dv, r_fd;
  logic [PIX_W-1:0] w_lb1, w_lb2;
  logic [PIX_W-1:0] r_win [9];
  logic [PIX_W-1:0] r_out [9];
  logic [PIX_W-1:0] w_nxt [9];
  // An iSof pixel is always taken as (0,0), whatever state or position the frame was in
  always_comb begin
    w_sof      = iDataValid & iSof;
    w_accept   = w_sof | (iDataValid & (r_state == FILL || r_state == STREAM));
    w_col_last = r_col == CW'(IMG_WIDTH - 1);
    w_row_last = r_row == RW'(IMG_HEIGHT - 1);
    w_emit     = iDataValid & ~iSof & (r_state == STREAM) & (r_col >= CW'(2));
    w_done     = w_emit & w_col_last & w_row_last;
    w_addr     = w_sof ? '0 : r_col;
    w_next     = w_sof ? FILL : w_done ? DONE :
                 (w_accept && r_state == FILL && w_col_last && r_row == RW'(1)) ? STREAM : r_state;
  end
  always_comb begin
    w_nxt[WIN_A]   = r_win[WIN_B];
    w_nxt[WIN_B]   = r_win[WIN_C];
    w_nxt[WIN_C]   = w_lb2;
    w_nxt[WIN_D]   = r_win[WIN_FIJ];
    w_nxt[WIN_FIJ] = r_win[WIN_E];
    w_nxt[WIN_E]   = w_lb1;
    w_nxt[WIN_F]   = r_win[WIN_G];
    w_nxt[WIN_G]   = r_win[WIN_H];
    w_nxt[WIN_H]   = iv8Pixel;
  end
  dtbdm_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .i_clk(iClk), .i_we(w_accept), .i_addr(w_addr), .i_wr_data(iv8Pixel), .o_rd_data(w_lb1)
  );
  dtbdm_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .i_clk(iClk), .i_we(w_accept), .i_addr(w_addr), .i_wr_data(w_lb1), .o_rd_data(w_lb2)
  );
  always_ff @(posedge iClk)
    r_state <= iRst ? IDLE : w_next;
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_col <= '0;
      r_row <= '0;
      r_win <= '{default: '0};
      r_out <= '{default: '0};
      r_dv  <= 1'b0;
      r_fd  <= 1'b0;
    end else begin
      r_dv <= w_emit;
      r_fd <= w_done;
      if (w_accept) begin
        r_col <= w_sof ? CW'(1) : w_col_last ? '0 : r_col + CW'(1);
        r_row <= w_sof ? '0 : !w_col_last ? r_row : w_row_last ? '0 : r_row + RW'(1);
        r_win <= w_nxt;
      end
      if (w_emit) r_out <= w_nxt;
    end
  end
`ifdef DTBDM_WIN_CNT_EN
  logic [16:0] r_cnt;
  always_ff @(posedge iClk)
    r_cnt <= iRst ? '0 : w_sof ? '0 : (w_emit && r_cnt != '1) ? r_cnt + 17'd1 : r_cnt;
  assign ov17WinCount = r_cnt;
`endif
  assign ov8Pixel_a   = r_out[WIN_A];
  assign ov8Pixel_b   = r_out[WIN_B];
  assign ov8Pixel_c   = r_out[WIN_C];
  assign ov8Pixel_d   = r_out[WIN_D];
  assign ov8Pixel_fij = r_out[WIN_FIJ];
  assign ov8Pixel_e   = r_out[WIN_E];
  assign ov8Pixel_f   = r_out[WIN_F];
  assign ov8Pixel_g   = r_out[WIN_G];
  assign ov8Pixel_h   = r_out[WIN_H];
  assign oDataValid   = r_dv;
  assign oFrameDone   = r_fd;
endmodule

// File: tb/tb_dtbdm_window_gen.sv
// tb_dtbdm_window_gen: directed checks of the window generator on a 5x4 image of 10*row+col pixels
module tb_dtbdm_window_gen;
  localparam int W = 5;
  localparam int H = 4;
  logic iClk = 1'b0, iRst = 1'b1, iDataValid = 1'b0, iSof = 1'b0;
  logic [7:0] iv8Pixel = '0;
  logic [7:0] ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e;
  logic [7:0] ov8Pixel_f, ov8Pixel_g, ov8Pixel_h;
  logic oDataValid, oFrameDone;
`ifdef DTBDM_WIN_CNT_EN
  logic [16:0] ov17WinCount;
`endif
  int n_checks = 0, n_fail = 0, n_pulse = 0;
  logic [7:0] last_h = '0;

  dtbdm_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .iClk(iClk), .iRst(iRst), .iDataValid(iDataValid), .iSof(iSof), .iv8Pixel(iv8Pixel),
    .ov8Pixel_a(ov8Pixel_a), .ov8Pixel_b(ov8Pixel_b), .ov8Pixel_c(ov8Pixel_c),
    .ov8Pixel_d(ov8Pixel_d), .ov8Pixel_fij(ov8Pixel_fij), .ov8Pixel_e(ov8Pixel_e),
    .ov8Pixel_f(ov8Pixel_f), .ov8Pixel_g(ov8Pixel_g), .ov8Pixel_h(ov8Pixel_h),
`ifdef DTBDM_WIN_CNT_EN
    .ov17WinCount(ov17WinCount),
`endif
    .oDataValid(oDataValid), .oFrameDone(oFrameDone)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock with the given inputs; checks the registered result one step after the edge
  task automatic step(input logic v, input logic s, input logic [7:0] p,
                      input logic ev, input logic efd, input int r, input int c);
    logic [7:0] obs [9];
    iDataValid = v; iSof = s; iv8Pixel = p;
    @(posedge iClk); #1;
    iDataValid = 1'b0; iSof = 1'b0;
    obs = '{ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e,
            ov8Pixel_f, ov8Pixel_g, ov8Pixel_h};
    if (oDataValid) n_pulse++;
    chk($sformatf("valid(%0d,%0d)", r, c), 32'(oDataValid), 32'(ev));
    chk($sformatf("fdone(%0d,%0d)", r, c), 32'(oFrameDone), 32'(efd));
    if (ev) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("win(%0d,%0d)[%0d]", r, c, 3 * i + j), 32'(obs[3 * i + j]),
              32'(10 * (r - 2 + i) + (c - 2 + j)));
      last_h = 8'(10 * r + c);
    end else if (!v) chk("hold_h", 32'(ov8Pixel_h), 32'(last_h));
  endtask

  task automatic frame(input logic stall);
    n_pulse = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, r == 0 && c == 0, 8'(10 * r + c), r >= 2 && c >= 2, r == H - 1 && c == W - 1, r, c);
        if (stall) step(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, r, c);
      end
    chk("pulses", 32'(n_pulse), 32'd6);
  endtask

  task automatic partial;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 2) ? 3 : W); c++)
        step(1'b1, r == 0 && c == 0, 8'(10 * r + c), r == 2 && c == 2, 1'b0, r, c);
  endtask

  initial begin
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    chk("rst_valid", 32'(oDataValid), 32'd0);
    chk("rst_fdone", 32'(oFrameDone), 32'd0);
    chk("rst_a", 32'(ov8Pixel_a), 32'd0);
    chk("rst_h", 32'(ov8Pixel_h), 32'd0);
`ifdef DTBDM_WIN_CNT_EN
    chk("rst_cnt", 32'(ov17WinCount), 32'd0);
`endif
    step(1'b1, 1'b0, 8'd77, 1'b0, 1'b0, -1, -1);
    frame(1'b0);
`ifdef DTBDM_WIN_CNT_EN
    chk("cnt_frame", 32'(ov17WinCount), 32'd6);
`endif
    frame(1'b1);
    partial();
    frame(1'b0);
`ifdef DTBDM_WIN_CNT_EN
    chk("cnt_abort", 32'(ov17WinCount), 32'd6);
`endif
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 8'(90 + k), 1'b0, 1'b0, 9, k);
`ifdef DTBDM_WIN_CNT_EN
    chk("cnt_done_hold", 32'(ov17WinCount), 32'd6);
`endif
    frame(1'b0);
    partial();
    step(1'b1, 1'b0, 8'd23, 1'b1, 1'b0, 2, 3);
    iRst = 1'b1; iDataValid = 1'b1; iv8Pixel = 8'd24;
    @(posedge iClk); #1;
    iRst = 1'b0; iDataValid = 1'b0;
    chk("midrst_valid", 32'(oDataValid), 32'd0);
    chk("midrst_fdone", 32'(oFrameDone), 32'd0);
    chk("midrst_a", 32'(ov8Pixel_a), 32'd0);
    chk("midrst_e", 32'(ov8Pixel_e), 32'd0);
    chk("midrst_h", 32'(ov8Pixel_h), 32'd0);
`ifdef DTBDM_WIN_CNT_EN
    chk("midrst_cnt", 32'(ov17WinCount), 32'd0);
`endif
    last_h = '0;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 8'(30 + k), 1'b0, 1'b0, 8, k);
    frame(1'b0);
`ifdef DTBDM_WIN_CNT_EN
    chk("cnt_after_rst", 32'(ov17WinCount), 32'd6);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
